// File: rtl/seq_shifter.sv
// Multi-cycle shifter: SRL/SRA/SLL (and ROR) by a run-time amount, up to STEP bits per clock,
// under a start/ready/done handshake. Define SEQ_SHIFTER_ROTATE_EN to enable rotate-right on mode 11.
module seq_shifter #(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 1,
  localparam int SAW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [SAW-1:0]   shamt,
  input  logic [1:0]       mode,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [1:0] M_SRA = 2'b01;
  localparam logic [1:0] M_SLL = 2'b10;
`ifdef SEQ_SHIFTER_ROTATE_EN
  localparam logic [1:0] M_ROR = 2'b11;
`endif

  // One extra bit so STEP == WIDTH is representable.
  localparam int KW = SAW + 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SAW-1:0]   rem_q, rem_d;
  logic [1:0]       mode_q, mode_d;
  logic             sign_q, sign_d;

  logic [KW-1:0]    k;
  logic [WIDTH-1:0] hi_mask;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    sign_d  = sign_q;

    k       = ({1'b0, rem_q} < KW'(STEP)) ? {1'b0, rem_q} : KW'(STEP);
    hi_mask = ~({WIDTH{1'b1}} >> k);

    case (mode_q)
      M_SRA:   shifted = (work_q >> k) | (sign_q ? hi_mask : '0);
      M_SLL:   shifted = work_q << k;
`ifdef SEQ_SHIFTER_ROTATE_EN
      M_ROR:   shifted = (work_q >> k) | (work_q << (KW'(WIDTH) - k));
`endif
      default: shifted = work_q >> k;
    endcase

    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = A;
          rem_d   = shamt;
          mode_d  = mode;
          sign_d  = A[WIDTH-1];
          state_d = (shamt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        // k never exceeds rem, so the truncated slice is exact.
        work_d = shifted;
        rem_d  = rem_q - k[SAW-1:0];
        if (rem_d == '0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      mode_q  <= '0;
      sign_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register updates from the values held before the edge.
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      sign_q  <= sign_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign out   = work_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter: STEP=1 and STEP=4 instances against a behavioural shift model.
// Honours SEQ_SHIFTER_ROTATE_EN the same way as the design.
module tb_seq_shifter;
  localparam int W = 32;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [1:0]          start, ready, busy, done;
  logic [1:0][W-1:0]   a, res;
  logic [1:0][4:0]     shamt;
  logic [1:0][1:0]     mode;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(W), .STEP(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .A(a[0]), .shamt(shamt[0]), .mode(mode[0]),
    .ready(ready[0]), .busy(busy[0]), .done(done[0]), .out(res[0])
  );

  seq_shifter #(.WIDTH(W), .STEP(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .A(a[1]), .shamt(shamt[1]), .mode(mode[1]),
    .ready(ready[1]), .busy(busy[1]), .done(done[1]), .out(res[1])
  );

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int step_of(int idx);
    return (idx != 0) ? 4 : 1;
  endfunction

  // Single-cycle reference: plain operators on the whole word.
  function automatic logic [W-1:0] ref_shift(logic [W-1:0] av, int sh, logic [1:0] m);
    logic [2*W-1:0] dbl;
    dbl = {av, av} >> sh;
    case (m)
      2'b00:   return av >> sh;
      2'b01:   return W'($signed(av) >>> sh);
      2'b10:   return av << sh;
`ifdef SEQ_SHIFTER_ROTATE_EN
      default: return dbl[W-1:0];
`else
      default: return av >> sh;
`endif
    endcase
  endfunction

  function automatic int ref_lat(int idx, int sh);
    return 1 + (sh + step_of(idx) - 1) / step_of(idx);
  endfunction

  // Counts cycles after the accept edge until done; optionally pulses a bogus start in cycle 1.
  task automatic wait_done(int idx, bit inject, output int n, output bit side_ok);
    bit d;
    n = 0;
    side_ok = 1'b1;
    for (int c = 1; c <= W + 8; c++) begin
      @(negedge clk);
      d = done[idx];
      if (busy[idx] !== 1'b1 || ready[idx] !== 1'b0) side_ok = 1'b0;
      if (inject) begin
        start[idx] = (c == 1);
        if (c == 1) begin
          a[idx]     = $urandom;
          shamt[idx] = 5'($urandom);
          mode[idx]  = 2'($urandom);
        end
      end
      if (d) begin
        n = c;
        break;
      end
    end
  endtask

  task automatic run_op(int idx, logic [W-1:0] av, int sh, logic [1:0] m, bit inject, string tag);
    int n;
    bit ok;
    logic [W-1:0] exp;
    exp = ref_shift(av, sh, m);
    @(negedge clk);
    check({tag, ".ready"}, ready[idx], 1);
    start[idx] = 1'b1;
    a[idx]     = av;
    shamt[idx] = 5'(sh);
    mode[idx]  = m;
    @(posedge clk);
    #1;
    start[idx] = 1'b0;
    a[idx]     = $urandom;
    shamt[idx] = 5'($urandom);
    mode[idx]  = 2'($urandom);
    wait_done(idx, inject, n, ok);
    check({tag, ".lat"}, n, ref_lat(idx, sh));
    check({tag, ".out"}, res[idx], exp);
    check({tag, ".busy"}, ok, 1);
    @(negedge clk);
    check({tag, ".idle"}, {ready[idx], busy[idx], done[idx]}, 3'b100);
    check({tag, ".hold"}, res[idx], exp);
  endtask

  // start held high across two operations: second accept follows one idle cycle.
  task automatic b2b(int idx, logic [W-1:0] a1, int s1, logic [1:0] m1,
                     logic [W-1:0] a2, int s2, logic [1:0] m2);
    int n;
    bit ok;
    @(negedge clk);
    start[idx] = 1'b1;
    a[idx] = a1; shamt[idx] = 5'(s1); mode[idx] = m1;
    @(posedge clk);
    #1;
    wait_done(idx, 1'b0, n, ok);
    check("b2b.lat1", n, ref_lat(idx, s1));
    check("b2b.out1", res[idx], ref_shift(a1, s1, m1));
    a[idx] = a2; shamt[idx] = 5'(s2); mode[idx] = m2;
    @(negedge clk);
    check("b2b.gap", {ready[idx], done[idx]}, 2'b10);
    @(posedge clk);
    #1;
    start[idx] = 1'b0;
    wait_done(idx, 1'b0, n, ok);
    check("b2b.lat2", n, ref_lat(idx, s2));
    check("b2b.out2", res[idx], ref_shift(a2, s2, m2));
    @(negedge clk);
  endtask

  initial begin
    int sh;
    int idx;
    start = '0; a = '0; shamt = '0; mode = '0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst.out", res[i], 0);
      check("rst.flags", {ready[i], busy[i], done[i]}, 3'b100);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(0, 32'h8000_0000, 4, 2'b01, 1'b0, "t1_sra");
    run_op(0, 32'h8000_0000, 4, 2'b00, 1'b0, "t1_srl");
    run_op(0, 32'h0000_0001, 31, 2'b10, 1'b0, "t2_sll");
    run_op(1, 32'h0000_0001, 31, 2'b10, 1'b0, "t2_sll_s4");
    for (int m = 0; m < 4; m++) begin
      run_op(0, 32'h1234_5678, 0, 2'(m), 1'b0, "t3_zero");
      run_op(1, 32'h1234_5678, 0, 2'(m), 1'b0, "t3_zero_s4");
    end
    run_op(1, 32'hFFFF_0000, 5, 2'b01, 1'b1, "t4_inject");

    // Asynchronous reset in the middle of a SHIFT phase.
    @(negedge clk);
    start[0] = 1'b1; a[0] = 32'hFFFF_FFFF; shamt[0] = 5'd20; mode[0] = 2'b01;
    @(posedge clk);
    #1 start[0] = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst.out", res[0], 0);
    check("t5_rst.flags", {ready[0], busy[0], done[0]}, 3'b100);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 32'hFFFF_FFFF, 20, 2'b01, 1'b0, "t5_after");

    run_op(0, 32'h0000_000F, 4, 2'b11, 1'b0, "t6_ror");
    run_op(1, 32'h0000_000F, 4, 2'b11, 1'b0, "t6_ror_s4");

    b2b(0, 32'hA5A5_0F0F, 3, 2'b01, 32'h8765_4321, 7, 2'b11);
    b2b(1, 32'hC000_0001, 9, 2'b10, 32'h8000_00FF, 0, 2'b01);

    for (int i = 0; i < 60; i++) begin
      idx = i % 2;
      sh  = int'($urandom_range(31, 0));
      run_op(idx, $urandom, sh, 2'($urandom), (sh != 0) && ($urandom_range(3, 0) == 0), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
